dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM behind a fixed-latency memreq/ready handshake,
// with stall back-pressure and a misaligned-access error pulse.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        stall,
    output logic        err
);
    // state | meaning
    // IDLE  | no request outstanding; accepts memreq in the cycle it is seen
    // WAIT  | latency countdown in progress
    // RESP  | ready (and err) pulse; readdata valid
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int         DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [3:0] LOAD_COUNT = 4'(LATENCY - 1);

    state_t                state;
    state_t                nextState;
    logic [3:0]            count;
    logic [3:0]            nextCount;
    logic                  accept;
    logic                  enterResp;

    logic                  wrQ;
    logic                  misalignQ;
    logic [DEPTH_LOG2-1:0] idxQ;

    logic [DEPTH_LOG2-1:0] reqIdx;
    logic                  reqMisalign;
    logic [DEPTH_LOG2-1:0] curIdx;
    logic                  curMisalign;
    logic                  curWr;
    logic                  unusedAddrHi;

    logic [31:0]           mem [DEPTH];

    assign reqIdx       = addr[DEPTH_LOG2+1:2];
    assign reqMisalign  = |addr[1:0];
    assign unusedAddrHi = ^addr[31:DEPTH_LOG2+2];
    assign accept       = (state == IDLE) && memreq;

    // With LATENCY=1 the response is formed straight from the accept-cycle inputs.
    assign curIdx      = accept ? reqIdx      : idxQ;
    assign curMisalign = accept ? reqMisalign : misalignQ;
    assign curWr       = accept ? memwrite    : wrQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= nextState;
            count <= nextCount;
        end
    end

    always_comb begin
        nextState = state;
        nextCount = count;
        enterResp = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (memreq) begin
                    stall     = 1'b1;
                    nextCount = LOAD_COUNT;
                    if (LATENCY == 1) begin
                        nextState = RESP;
                        enterResp = 1'b1;
                    end else begin
                        nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                stall     = 1'b1;
                nextCount = count - 4'd1;
                if (count == 4'd1) begin
                    nextState = RESP;
                    enterResp = 1'b1;
                end
            end
            RESP: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata  <= 32'd0;
            ready     <= 1'b0;
            err       <= 1'b0;
            wrQ       <= 1'b0;
            misalignQ <= 1'b0;
            idxQ      <= '0;
        end else begin
            ready <= enterResp;
            err   <= enterResp && curMisalign;
            if (accept) begin
                wrQ       <= memwrite;
                misalignQ <= reqMisalign;
                idxQ      <= reqIdx;
            end
            if (enterResp && !curWr) begin
                readdata <= curMisalign ? 32'd0 : mem[curIdx];
            end
        end
    end

    // RAM has no reset so stores committed before a reset survive it.
    always_ff @(posedge clk) begin
        if (!reset && accept && memwrite && !reqMisalign) begin
            mem[reqIdx] <= writedata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table of requests with a scoreboard for ready-cycle
// responses, plus hand sequences for back-to-back, mid-op reset and LATENCY=1.
module tb_dmem_responder;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        memreq, memwrite, ready, stall, err;
    logic [31:0] addr, writedata, readdata;
    logic        memreq1, memwrite1, ready1, stall1, err1;
    logic [31:0] addr1, writedata1, readdata1;

    dmem_responder #(.DEPTH_LOG2(6), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .memreq(memreq), .memwrite(memwrite),
        .addr(addr), .writedata(writedata), .readdata(readdata),
        .ready(ready), .stall(stall), .err(err)
    );

    dmem_responder #(.DEPTH_LOG2(6), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .memreq(memreq1), .memwrite(memwrite1),
        .addr(addr1), .writedata(writedata1), .readdata(readdata1),
        .ready(ready1), .stall(stall1), .err(err1)
    );

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] expRd;
        logic        expErr;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } sb_t;

    sb_t         sbq[$];
    vec_t        vecs[12];
    int          nChecks = 0;
    int          nPass   = 0;
    int          cyc     = 0;
    logic [31:0] lastRd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Scoreboard consumer: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        sb_t e;
        if (ready === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_ready", ready, 0);
            end else begin
                e = sbq.pop_front();
                check("ready_cycle", cyc, e.cyc);
                check("readdata", readdata, e.rd);
                check("err", err, e.err);
            end
        end
    end

    task automatic doReq(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] expRd, input logic expErr);
        sb_t  e;
        logic stallOk;
        logic got;
        @(posedge clk); #1;
        memreq = 1'b1; memwrite = wr; addr = a; writedata = wd;
        e.rd  = wr ? lastRd : expRd;
        e.err = expErr;
        e.cyc = cyc + 2;
        if (!wr) lastRd = expRd;
        sbq.push_back(e);
        @(negedge clk);
        stallOk = (stall === 1'b1) && (ready === 1'b0);
        @(posedge clk); #1;
        // Post-accept input changes must not affect the transaction.
        memwrite = ~wr; addr = a ^ 32'h0000_00F5; writedata = ~wd;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                got = 1'b1;
                if (stall !== 1'b0) stallOk = 1'b0;
            end else if (stall !== 1'b1) begin
                stallOk = 1'b0;
            end
        end
        check("stall_pattern", stallOk, 1);
        check("ready_seen", got, 1);
        if (!got && sbq.size() > 0) void'(sbq.pop_front());
        @(posedge clk); #1;
        memreq = 1'b0;
    endtask

    initial begin
        sb_t  e;
        int   c;
        logic sawReady;
        reset = 1'b1;
        memreq = 1'b0; memwrite = 1'b0; addr = '0; writedata = '0;
        memreq1 = 1'b0; memwrite1 = 1'b0; addr1 = '0; writedata1 = '0;
        lastRd = 32'd0;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0, 32'h1234_5678, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 32'h0, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 32'h0, 1'b1};
        vecs[6]  = '{1'b0, 32'h0000_0020, 32'h0, 32'hA5A5_A5A5, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0021, 32'h0, 32'h0, 1'b1};
        vecs[8]  = '{1'b1, 32'h0000_00FC, 32'h0BAD_F00D, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_01FC, 32'h0, 32'h0BAD_F00D, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_0003, 32'h0, 32'h0, 1'b1};
        vecs[11] = '{1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_readdata", readdata, 0);
        check("rst_ready", ready, 0);
        check("rst_err", err, 0);
        check("rst_stall", stall, 0);
        check("rst_readdata_l1", readdata1, 0);

        for (int i = 0; i < 12; i++)
            doReq(vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].expRd, vecs[i].expErr);

        // Back-to-back loads with memreq held high: ready 3 cycles apart.
        @(posedge clk); #1;
        memreq = 1'b1; memwrite = 1'b0; addr = 32'h10;
        c = cyc;
        e = '{32'hDEAD_BEEF, 1'b0, c + 2};
        sbq.push_back(e);
        e = '{32'h1234_5678, 1'b0, c + 5};
        sbq.push_back(e);
        lastRd = 32'h1234_5678;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("b2b_stall", stall, ((i % 3) != 2) ? 1 : 0);
            check("b2b_ready", ready, ((i % 3) == 2) ? 1 : 0);
            if (i == 2) addr = 32'h0;
        end
        @(posedge clk); #1;
        memreq = 1'b0;

        // Reset during WAIT abandons the load.
        @(posedge clk); #1;
        memreq = 1'b1; memwrite = 1'b0; addr = 32'h10;
        @(negedge clk);
        check("mid_accept_stall", stall, 1);
        @(posedge clk); #1;
        reset = 1'b1; memreq = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        lastRd = 32'd0;
        sawReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) check("mid_stall_after_rst", stall, 0);
            sawReady = sawReady | ready;
        end
        check("mid_no_ready", sawReady, 0);
        check("mid_readdata", readdata, 0);
        doReq(1'b0, 32'h0000_0100, 32'h0, 32'h1234_5678, 1'b0);
        doReq(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // LATENCY=1 instance: store then load, ready one cycle after accept.
        @(posedge clk); #1;
        memreq1 = 1'b1; memwrite1 = 1'b1; addr1 = 32'h8; writedata1 = 32'h0000_0077;
        @(negedge clk);
        check("l1_st_stall", stall1, 1);
        check("l1_st_ready", ready1, 0);
        @(posedge clk); #1;
        memwrite1 = 1'b0; writedata1 = 32'h0;
        @(negedge clk);
        check("l1_st_resp_ready", ready1, 1);
        check("l1_st_resp_stall", stall1, 0);
        check("l1_st_resp_err", err1, 0);
        check("l1_st_readdata", readdata1, 0);
        @(negedge clk);
        check("l1_ld_stall", stall1, 1);
        check("l1_ld_ready", ready1, 0);
        @(negedge clk);
        check("l1_ld_resp_ready", ready1, 1);
        check("l1_ld_resp_stall", stall1, 0);
        check("l1_ld_readdata", readdata1, 32'h0000_0077);
        @(posedge clk); #1;
        memreq1 = 1'b0;
        @(negedge clk);
        check("l1_idle_ready", ready1, 0);
        check("l1_idle_stall", stall1, 0);

        repeat (3) @(posedge clk);
        check("sb_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
